// File: rtl/motor_speed_ctrl.sv
// Closed-loop motor speed controller: counts encoder edges per window, runs a
// saturating PI update once per window and drives a glitch-free PWM output.
module motor_speed_ctrl #(
    parameter int WINDOW_CYCLES = 12500000,
    parameter int PWM_PERIOD    = 5000,
    parameter int KP            = 4,
    parameter int KI_SHIFT      = 3,
    parameter int INTEG_LIM     = 1048575,
    parameter int STALL_WINDOWS = 5
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        enable,
    input  logic [15:0] target_edges,
    input  logic        inp_fbp,
    output logic        pwm_out,
    output logic [12:0] duty,
    output logic [15:0] meas_edges,
    output logic        meas_valid,
    output logic        stall
);

    localparam int WIN_W   = $clog2(WINDOW_CYCLES);
    localparam int STALL_W = $clog2(STALL_WINDOWS + 1);
    localparam logic signed [31:0] KP_S   = 32'(KP);
    localparam logic signed [31:0] PWM_S  = 32'(PWM_PERIOD);
    localparam logic signed [21:0] LIM_HI = 22'(INTEG_LIM);
    localparam logic signed [21:0] LIM_LO = -LIM_HI;

    typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_UPDATE, ST_STALL} state_t;

    state_t state, state_nxt;

    logic               fbp_p0, fbp_p1, fbp_p2;
    logic               edge_det;
    logic [WIN_W-1:0]   win_cnt;
    logic               win_term;
    logic [15:0]        edge_cnt;
    logic [STALL_W-1:0] stall_cnt, stall_cnt_inc;
    logic               stall_qual, stall_hit;
    logic [12:0]        duty_tgt;
    logic [12:0]        pwm_cnt;

    logic signed [16:0] err;
    logic signed [20:0] integ, integ_next;
    logic signed [21:0] integ_sum;
    logic signed [31:0] err_w, ki_w, u;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
        logic [16:0] s;
        s = {1'b0, v} + {16'd0, inc};
        sat_inc16 = s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic signed [20:0] clamp_integ(input logic signed [21:0] v);
        if (v > LIM_HI)
            clamp_integ = LIM_HI[20:0];
        else if (v < LIM_LO)
            clamp_integ = LIM_LO[20:0];
        else
            clamp_integ = v[20:0];
    endfunction

    function automatic logic [12:0] clamp_duty(input logic signed [31:0] v);
        if (v < 0)
            clamp_duty = 13'd0;
        else if (v > PWM_S)
            clamp_duty = 13'(PWM_PERIOD);
        else
            clamp_duty = v[12:0];
    endfunction

    // Stage p0..p2: encoder synchroniser and rising-edge detect
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fbp_p0 <= 1'b0;
            fbp_p1 <= 1'b0;
            fbp_p2 <= 1'b0;
        end else begin
            fbp_p0 <= inp_fbp;
            fbp_p1 <= fbp_p0;
            fbp_p2 <= fbp_p1;
        end
    end

    assign edge_det = fbp_p1 & ~fbp_p2;
    assign win_term = (state == ST_MEASURE) && (win_cnt == WIN_W'(WINDOW_CYCLES - 1));

    // PI arithmetic, evaluated against the freshly latched meas_edges in UPDATE
    assign err        = {1'b0, target_edges} - {1'b0, meas_edges};
    assign integ_sum  = {integ[20], integ} + {{5{err[16]}}, err};
    assign integ_next = clamp_integ(integ_sum);
    assign err_w      = err;
    assign ki_w       = integ_next >>> KI_SHIFT;
    assign u          = KP_S * err_w + ki_w;

    assign stall_qual    = (duty_tgt == 13'(PWM_PERIOD)) && (meas_edges == 16'd0);
    assign stall_cnt_inc = stall_cnt + 1'b1;
    assign stall_hit     = stall_qual && (stall_cnt_inc == STALL_W'(STALL_WINDOWS));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (enable) state_nxt = ST_MEASURE;
            ST_MEASURE: if (win_term) state_nxt = ST_UPDATE;
            ST_UPDATE:  state_nxt = stall_hit ? ST_STALL : ST_MEASURE;
            ST_STALL:   state_nxt = ST_STALL;
            default:    state_nxt = ST_IDLE;
        endcase
        if (!enable)
            state_nxt = ST_IDLE;
    end

    assign stall = (state == ST_STALL);

    // Measurement window and control update
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win_cnt    <= '0;
            edge_cnt   <= 16'd0;
            meas_edges <= 16'd0;
            meas_valid <= 1'b0;
            integ      <= '0;
            stall_cnt  <= '0;
            duty_tgt   <= 13'd0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable || state == ST_IDLE) begin
                win_cnt   <= '0;
                edge_cnt  <= 16'd0;
                integ     <= '0;
                stall_cnt <= '0;
                duty_tgt  <= 13'd0;
            end else begin
                case (state)
                    ST_MEASURE: begin
                        if (win_term) begin
                            win_cnt    <= '0;
                            edge_cnt   <= 16'd0;
                            meas_edges <= sat_inc16(edge_cnt, edge_det);
                            meas_valid <= 1'b1;
                        end else begin
                            win_cnt  <= win_cnt + 1'b1;
                            edge_cnt <= sat_inc16(edge_cnt, edge_det);
                        end
                    end
                    ST_UPDATE: begin
                        // Edges seen here already belong to the new window
                        edge_cnt  <= sat_inc16(edge_cnt, edge_det);
                        integ     <= integ_next;
                        duty_tgt  <= clamp_duty(u);
                        stall_cnt <= stall_qual ? stall_cnt_inc : '0;
                    end
                    ST_STALL: duty_tgt <= 13'd0;
                    default:  duty_tgt <= 13'd0;
                endcase
            end
        end
    end

    // PWM: applied duty only changes at the period wrap
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pwm_cnt <= 13'd0;
            duty    <= 13'd0;
            pwm_out <= 1'b0;
        end else begin
            if (pwm_cnt == 13'(PWM_PERIOD - 1)) begin
                pwm_cnt <= 13'd0;
                duty    <= duty_tgt;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Directed bench for motor_speed_ctrl with a short window and PWM period so
// every loop behaviour is reachable in a few thousand cycles.
module tb_motor_speed_ctrl;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] target_edges = 16'd0;
    logic        inp_fbp = 1'b0;
    logic        pwm_out;
    logic [12:0] duty;
    logic [15:0] meas_edges;
    logic        meas_valid;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;
    int hi       = 0;

    motor_speed_ctrl #(
        .WINDOW_CYCLES(1000),
        .PWM_PERIOD(100),
        .KP(1),
        .KI_SHIFT(2),
        .INTEG_LIM(1048575),
        .STALL_WINDOWS(3)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .enable(enable),
        .target_edges(target_edges),
        .inp_fbp(inp_fbp),
        .pwm_out(pwm_out),
        .duty(duty),
        .meas_edges(meas_edges),
        .meas_valid(meas_valid),
        .stall(stall)
    );

    always #4 clk = ~clk;

    always @(negedge clk)
        if (meas_valid === 1'b1) vcount <= vcount + 1;

    initial begin
        #(40000 * 8);
        $display("FAIL watchdog: observed no end of test, expected end within 40000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int h, input int l);
        inp_fbp = 1'b1;
        repeat (h) @(negedge clk);
        inp_fbp = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (meas_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, meas_valid}, 32'd1);
    endtask

    task automatic wait_duty(input string tag, input int val, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (duty !== 13'(val) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, {19'd0, duty}, 32'(val));
    endtask

    task automatic count_high(input int cycles, output int h);
        h = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (pwm_out === 1'b1) h++;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pwm_out", {31'd0, pwm_out}, 32'd0);
        check("rst_duty", {19'd0, duty}, 32'd0);
        check("rst_meas_edges", {16'd0, meas_edges}, 32'd0);
        check("rst_meas_valid", {31'd0, meas_valid}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);

        // Reset mid-window, then release with the loop disabled
        n_rst = 1'b1;
        enable = 1'b1;
        target_edges = 16'd50;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 10; i++) pulse(2, 2);
        repeat (200) @(negedge clk);
        #2 n_rst = 1'b0;
        #1 check("async_rst_meas_edges", {16'd0, meas_edges}, 32'd0);
        check("async_rst_duty", {19'd0, duty}, 32'd0);
        @(negedge clk);
        enable = 1'b0;
        n_rst = 1'b1;
        repeat (1400) @(negedge clk);
        count_high(100, hi);
        check("idle_pwm_high", 32'(hi), 32'd0);
        check("idle_duty", {19'd0, duty}, 32'd0);
        check("idle_no_valid", 32'(vcount), 32'd0);

        // First window, no pulses: err 10, integ 10, u = 12
        target_edges = 16'd10;
        enable = 1'b1;
        wait_valid("w1_valid", 1100);
        check("w1_meas_edges", {16'd0, meas_edges}, 32'd0);
        repeat (2) @(negedge clk);
        target_edges = 16'd20;
        wait_duty("w1_duty12", 12, 150);
        repeat (3) @(negedge clk);
        count_high(100, hi);
        check("w1_pwm_high12", 32'(hi), 32'd0 + 32'd12);

        // 25 pulses against target 20: err -5, integ 5, u = -4 -> duty 0
        for (int i = 0; i < 25; i++) pulse(2, 2);
        wait_valid("w2_valid", 1000);
        check("w2_meas_edges", {16'd0, meas_edges}, 32'd25);
        @(negedge clk);
        check("w2_valid_one_cycle", {31'd0, meas_valid}, 32'd0);
        wait_duty("w2_duty0", 0, 150);

        // Edge detected on the terminal cycle counts in the closing window
        enable = 1'b0;
        target_edges = 16'd0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) pulse(2, 2);
        repeat (972) @(negedge clk);
        inp_fbp = 1'b1;
        repeat (2) @(negedge clk);
        inp_fbp = 1'b0;
        wait_valid("term_valid", 5);
        check("term_meas_edges", {16'd0, meas_edges}, 32'd5);
        wait_valid("next_valid", 1100);
        check("next_meas_edges", {16'd0, meas_edges}, 32'd0);

        // Saturated drive with no feedback trips stall after 3 qualifying windows
        enable = 1'b0;
        repeat (3) @(negedge clk);
        target_edges = 16'd1000;
        enable = 1'b1;
        wait_valid("s1_valid", 1100);
        wait_duty("s1_duty100", 100, 150);
        repeat (3) @(negedge clk);
        count_high(100, hi);
        check("s1_pwm_high100", 32'(hi), 32'd100);
        wait_valid("s2_valid", 1100);
        wait_valid("s3_valid", 1100);
        @(negedge clk);
        check("s3_no_stall", {31'd0, stall}, 32'd0);
        wait_valid("s4_valid", 1100);
        @(negedge clk);
        check("s4_stall", {31'd0, stall}, 32'd1);
        wait_duty("stall_duty0", 0, 150);
        repeat (3) @(negedge clk);
        count_high(100, hi);
        check("stall_pwm_high", 32'(hi), 32'd0);
        check("stall_held", {31'd0, stall}, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("stall_cleared", {31'd0, stall}, 32'd0);
        enable = 1'b1;

        // Edge counter saturates at 0xFFFF rather than wrapping
        target_edges = 16'd0;
        repeat (5) @(negedge clk);
        force dut.edge_cnt = 16'hFFF0;
        @(negedge clk);
        release dut.edge_cnt;
        for (int i = 0; i < 40; i++) pulse(1, 1);
        wait_valid("sat_valid", 1100);
        check("sat_meas_edges", {16'd0, meas_edges}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
